// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the write port of an async FIFO among NUM_REQ requesters.
// A grant is held until the owner's last beat or MAX_BURST beats, so packets are never interleaved.

module fifo_wr_arbiter_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  gnt,
    input  logic                  fifo_wfull,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_sel
);
    assign ready    = gnt & ~fifo_wfull;
    assign data_sel = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 16,
    localparam int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_wfull,
    output logic                          fifo_wren,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          beat_cnt
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                             state, state_nxt;
    logic [NUM_REQ-1:0]                 grant_nxt;
    logic [CNT_WIDTH-1:0]               beat_cnt_nxt;
    logic [IDX_W-1:0]                   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]                   owner, owner_nxt;
    logic [IDX_W-1:0]                   winner;
    logic                               any_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic                               xfer, last_beat, release_burst;

    // Per-requester ready gating and data steering; grant is zero in IDLE, so both vanish there.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .gnt        (grant[gi]),
                .fifo_wfull (fifo_wfull),
                .data       (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .ready      (req_ready[gi]),
                .data_sel   (lane_data[gi])
            );
        end
    endgenerate

    always_comb begin
        fifo_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++)
            fifo_wdata = fifo_wdata | lane_data[k];
    end

    // Scan from the highest offset down so the nearest valid index after rr_ptr wins.
    always_comb begin
        logic [IDX_W:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ))
                idx = idx - (IDX_W+1)'(NUM_REQ);
            if (req_valid[idx[IDX_W-1:0]]) begin
                winner    = idx[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign busy          = (state == BURST);
    assign xfer          = busy & |(grant & req_valid) & ~fifo_wfull;
    assign last_beat     = |(grant & req_last);
    assign release_burst = xfer & (last_beat | (beat_cnt == CNT_WIDTH'(MAX_BURST - 1)));
    assign fifo_wren     = xfer;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt    = BURST;
                    grant_nxt    = NUM_REQ'(1) << winner;
                    owner_nxt    = winner;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (release_burst) begin
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
        end
    end

    // Writing into a full FIFO would silently drop a beat.
    a_no_write_when_full: assert property (@(posedge clk) disable iff (reset) !(fifo_wren && fifo_wfull));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: a packet-level round-robin model predicts every FIFO write; a monitor pops and compares.
module tb_fifo_wr_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int MB    = 16;
    localparam int CW    = $clog2(MB + 1);
    localparam int DEPTH = 512;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid, req_last, req_ready, grant;
    logic [NR*DW-1:0] req_data;
    logic             fifo_wfull, fifo_wren, busy;
    logic [DW-1:0]    fifo_wdata;
    logic [CW-1:0]    beat_cnt;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wfull (fifo_wfull),
        .fifo_wren  (fifo_wren),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          beat;
    } exp_t;

    exp_t          sbq[$];
    int            wr_cyc[$];
    logic [DW-1:0] bdata[NR][DEPTH];
    logic          blast[NR][DEPTH];
    int            head[NR], tail[NR], mhead[NR];
    int            mptr;
    logic [NR-1:0] fire;
    bit            wfull_nxt, sb_en, drop_en;
    int            wfull_pct;
    int            errors = 0, checks = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pending();
        for (int r = 0; r < NR; r++)
            if (head[r] < tail[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_q();
        for (int r = 0; r < NR; r++) begin
            head[r] = 0; tail[r] = 0; mhead[r] = 0;
        end
        fire = '0;
    endtask

    task automatic add_pkt(input int r, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            bdata[r][tail[r]] = base + DW'(k);
            blast[r][tail[r]] = (k == len - 1);
            tail[r]++;
        end
    endtask

    // Packet-level model: everything loaded is pending at once; each arbitration picks the
    // first requester with data from mptr onward and takes beats up to last or MB.
    task automatic build_expect();
        bit more;
        more = 1'b1;
        while (more) begin
            int  w, n;
            bit  done;
            exp_t e;
            w = -1;
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (mptr + k) % NR;
                if (w < 0 && mhead[j] < tail[j]) w = j;
            end
            if (w < 0) begin
                more = 1'b0;
            end else begin
                n = 0; done = 1'b0;
                while (!done && mhead[w] < tail[w]) begin
                    e.id = w; e.data = bdata[w][mhead[w]]; e.beat = n;
                    sbq.push_back(e);
                    done = blast[w][mhead[w]] || (n == MB - 1);
                    mhead[w]++;
                    n++;
                end
                mptr = (w + 1) % NR;
            end
        end
    endtask

    // One clock of requester behaviour: retire beats accepted at the edge, present the next ones.
    task automatic step();
        @(posedge clk); #1;
        for (int r = 0; r < NR; r++)
            if (fire[r]) head[r]++;
        for (int r = 0; r < NR; r++) begin
            bit pend;
            pend = head[r] < tail[r];
            req_valid[r] = pend && !(drop_en && grant[r] && $urandom_range(0, 3) == 0);
            req_data[r*DW +: DW] = pend ? bdata[r][head[r]] : '0;
            req_last[r] = pend ? blast[r][head[r]] : 1'b0;
        end
        fifo_wfull = (wfull_pct > 0) ? ($urandom_range(0, 99) < wfull_pct) : wfull_nxt;
        #3;
        fire = req_valid & req_ready;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sbq.size() != 0 || pending()) && n < budget) begin
            step();
            n++;
        end
        chk("drain_within_budget", 64'(n < budget), 1);
        step();
    endtask

    // Monitor: compares every write against the scoreboard and checks cycle-level invariants.
    initial begin
        logic [NR-1:0] pg;
        exp_t          e;
        pg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("wren_while_full", fifo_wren & fifo_wfull, 0);
                chk("ready_vs_grant", req_ready, grant & {NR{~fifo_wfull}});
                chk("busy_vs_grant", busy, |grant);
                if (pg != 0 && grant != 0 && grant != pg)
                    chk("idle_gap_between_owners", grant, 0);
                if (fifo_wren && sb_en) begin
                    wr_cyc.push_back(cyc);
                    chk("write_expected", 64'(sbq.size() > 0), 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("wdata", fifo_wdata, e.data);
                        chk("owner", grant, 64'(1) << e.id);
                        chk("beat_cnt", beat_cnt, e.beat);
                    end
                end
                pg = grant;
            end else begin
                pg = '0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_q();
        mptr = 0; sb_en = 1'b1; drop_en = 1'b0; wfull_pct = 0; wfull_nxt = 1'b0;
        reset = 1'b1; fifo_wfull = 1'b0;
        req_valid = '1; req_last = '1; req_data = {NR{32'hDEADBEEF}};
        #12;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_wren", fifo_wren, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", fifo_wdata, 0);
        req_valid = '0; req_last = '0; req_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single requester, 3-beat packet
        add_pkt(1, 3, 32'hA0);
        build_expect();
        step();
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_wren", fifo_wren, 0);
        step();
        chk("t1_grant", grant, 4'b0010);
        chk("t1_beat0", fifo_wdata, 32'hA0);
        step();
        chk("t1_beat1", fifo_wdata, 32'hA1);
        step();
        chk("t1_beat2", fifo_wdata, 32'hA2);
        step();
        chk("t1_back_idle", busy, 0);
        drain(50);

        // rr_ptr is now 2: requester 3 must beat requester 1
        clear_q();
        add_pkt(1, 1, 32'hB1);
        add_pkt(3, 1, 32'hB3);
        build_expect();
        step(); step();
        chk("t1_rrptr_winner", grant, 4'b1000);
        drain(50);

        reset = 1'b1; #2; reset = 1'b0;
        mptr = 0;

        // All four requesters, two 1-beat packets each: one write every 2 cycles
        clear_q();
        wr_cyc.delete();
        for (int r = 0; r < NR; r++) begin
            add_pkt(r, 1, 32'h200 + 32'(r * 16));
            add_pkt(r, 1, 32'h201 + 32'(r * 16));
        end
        build_expect();
        drain(100);
        chk("t2_writes", wr_cyc.size(), 8);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("t2_write_spacing", wr_cyc[i] - wr_cyc[i-1], 2);

        // Long stream from 0 against requester 2: forced release after MB beats
        clear_q();
        add_pkt(0, 21, 32'h300);
        add_pkt(2, 1, 32'h3F0);
        build_expect();
        drain(200);

        // FIFO full for 5 cycles during beat 2 of a 4-beat burst
        clear_q();
        add_pkt(1, 4, 32'h400);
        build_expect();
        step();
        for (int k = 1; k <= 12; k++) begin
            wfull_nxt = (k >= 2 && k <= 6);
            step();
            if (k >= 2 && k <= 6) begin
                chk("t4_full_wren", fifo_wren, 0);
                chk("t4_full_ready", req_ready, 0);
                chk("t4_full_beat_cnt", beat_cnt, 1);
            end
        end
        wfull_nxt = 1'b0;
        drain(50);

        // Last beat held off by full for 2 cycles
        clear_q();
        add_pkt(2, 2, 32'h500);
        build_expect();
        step();
        wfull_nxt = 1'b0; step();
        wfull_nxt = 1'b1; step();
        chk("t5_hold_busy_a", busy, 1);
        step();
        chk("t5_hold_busy_b", busy, 1);
        chk("t5_hold_wren", fifo_wren, 0);
        wfull_nxt = 1'b0; step();
        chk("t5_last_wren", fifo_wren, 1);
        chk("t5_last_data", fifo_wdata, 32'h501);
        step();
        chk("t5_idle_after", busy, 0);
        drain(50);

        // Reset mid-burst from requester 3, then arbitration restarts at rr_ptr=0
        clear_q();
        add_pkt(2, 1, 32'h600);
        build_expect();
        drain(50);
        clear_q();
        sb_en = 1'b0;
        add_pkt(3, 4, 32'h610);
        step(); step(); step();
        chk("t6_pre_beat_cnt", beat_cnt, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_beat_cnt", beat_cnt, 0);
        chk("t6_rst_wren", fifo_wren, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_wdata", fifo_wdata, 0);
        clear_q();
        step();
        reset = 1'b0;
        mptr = 0;
        sbq.delete();
        sb_en = 1'b1;
        clear_q();
        add_pkt(1, 1, 32'h621);
        add_pkt(3, 1, 32'h623);
        build_expect();
        step(); step();
        chk("t6_post_rst_grant", grant, 4'b0010);
        drain(50);

        // Randomized rounds: packet lengths, data, mid-burst valid drops and full back-pressure
        drop_en = 1'b1;
        wfull_pct = 25;
        for (int rnd = 0; rnd < 20; rnd++) begin
            clear_q();
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int npk;
                    npk = $urandom_range(1, 2);
                    for (int p = 0; p < npk; p++)
                        add_pkt(r, $urandom_range(1, 20), $urandom);
                end
            end
            build_expect();
            drain(2000);
        end
        drop_en = 1'b0;
        wfull_pct = 0;

        chk("sb_empty_at_end", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
